nios_pio_in_edge: RTL
=====================

// Module: nios_pio_in_edge
// PURPOSE
//  Avalon-MM slave input PIO for Nios II peripheral systems (keys, switches).
//  - Synchronises an external input bus and exposes it as a readable data register.
//  - Captures selected edges per bit into sticky flags and raises a maskable level interrupt.
//  - Input-side counterpart to the team's output PIO slaves (7-seg, LEDs).
// PARAMETERS
//  WIDTH        8   input bus width; legal 1..32, elaboration error otherwise
//  EDGE_TYPE    0   0 = rising, 1 = falling, 2 = any edge
//  SYNC_STAGES  2   synchroniser depth; legal 2..4
// PORTS
//  clk         in   1      system clock
//  reset_n     in   1      reset, asynchronous, active-low
//  address     in   2      word address: 0 data, 1 rsvd, 2 irqmask, 3 edgecapture
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe, qualified by chipselect
//  writedata   in   32     write data; bits above WIDTH ignored
//  in_port     in   WIDTH  asynchronous external inputs
//  readdata    out  32     registered read data, zero-extended
//  irq         out  1      level interrupt to the CPU
// BEHAVIOUR
//  Reset: sync chain, prev, irq_mask, edge_capture, readdata = 0; irq = 0; armed = 0.
//  Synchroniser and arming:
//   - in_port passes SYNC_STAGES flops -> data_in; prev <= data_in every cycle.
//   - armed: a counter sets it SYNC_STAGES+1 cycles after reset release.
//   - Edges are ignored while armed = 0, so a level held through reset never captures.
//  Edge detect, per bit:
//   - rise = data_in & ~prev; fall = ~data_in & prev; any = data_in ^ prev.
//   - edge_det selected by EDGE_TYPE, gated by armed.
//  Write (chipselect & ~write_n):
//   - addr 2: irq_mask <= writedata[WIDTH-1:0].
//   - addr 3: write-1-to-clear; bit i cleared when writedata[i] = 1.
//   - addr 0 and addr 1: ignored.
//  edge_capture update: set on edge_det[i], else clear on a W1C write, else hold.
//   - Set wins over clear in the same cycle.
//  irq = |(edge_capture & irq_mask), driven combinationally from registers.
//   - Asserts in the cycle edge_capture sets; deasserts the cycle after the clearing write or mask write.
//  Read:
//   - readdata <= mux(address) every cycle chipselect = 1; holds otherwise.
//   - Fixed 1-cycle read latency; no wait states; reads have no side effects.
//   - addr 0 = data_in, 1 = 0, 2 = irq_mask, 3 = edge_capture; unused upper bits read 0.
//  Latency:
//   - in_port change at edge N shows in data_in after SYNC_STAGES edges.
//   - It reaches readdata 1 edge later; capture flag and irq are 1 edge after data_in.
//  Input pulses shorter than one clk period may be missed; this is by design.
//  reset_n assert mid-operation: immediate async clear of all state and re-arm sequence.
// STRUCTURE
//  Package nios_pio_pkg:
//   - ADDR_DATA = 0, ADDR_RSVD = 1, ADDR_IRQMASK = 2, ADDR_EDGECAP = 3.
//   - EDGE_RISE = 0, EDGE_FALL = 1, EDGE_ANY = 2.
//  Sub-module pio_sync_edge, parameterised by WIDTH/EDGE_TYPE/SYNC_STAGES:
//   - Synchroniser, prev register, arming counter.
//   - Outputs data_in and edge_det.
//  Top holds the register file, read mux and irq.
// TESTING  (WIDTH = 8, EDGE_TYPE = 0, SYNC_STAGES = 2 unless stated)
//  1. in_port = 8'hFF through reset, release, wait 10 cycles -> edge_capture = 0, irq = 0, read addr 0 = 32'h000000FF.
//  2. in_port 8'h00 -> 8'h05, mask = 8'h01 -> read addr 3 = 32'h05; irq = 1 exactly 3 edges after the change.
//  3. Write addr 3 = 32'h01 -> edge_capture = 8'h04, irq = 0 next cycle.
//     Then write addr 2 = 8'h04 -> irq = 1.
//  4. Rising edge on bit 0 in the same cycle as a W1C write of 32'h01 -> bit 0 remains set.
//  5. EDGE_TYPE = 2, toggle bit 7 twice; write addr 0 = 32'hFFFF and addr 1 -> capture bit 7 set.
//     Reads of addr 0 and addr 1 unaffected by the writes; readdata[31:8] = 0 always.
//  6. Assert reset_n low mid-capture with irq = 1 -> irq, readdata and mask = 0 asynchronously; re-arm delay repeats.

Source files
------------

// File: rtl/nios_pio_pkg.sv
`default_nettype none
// ============================================================================
// Package     : nios_pio_pkg
// Description : Shared register map and edge-type encodings for the Nios II
//               PIO slaves.
// Revision    : 1.0 - initial release
// ============================================================================
package nios_pio_pkg;

  // Avalon word addresses of the input PIO register file
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // Edge-type selection for the capture logic
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage : nios_pio_pkg
`default_nettype wire

// File: rtl/pio_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : pio_sync_edge
// Description : Multi-stage synchroniser for an asynchronous input bus, a
//               previous-value register, per-bit edge detection, and an arming
//               counter that suppresses edges until the synchroniser has
//               flushed after reset.
// Ports       : clk      - system clock
//               reset_n  - asynchronous active-low reset
//               in_port  - asynchronous external inputs [WIDTH]
//               data_in  - synchronised input value [WIDTH]
//               edge_det - one-cycle per-bit edge pulses, gated by arming
// Revision    : 1.0 - initial release
// ============================================================================
module pio_sync_edge
  import nios_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] edge_det
);

  // Wide enough to count up to the largest legal SYNC_STAGES (4)
  localparam int c_ARM_CNT_W = 3;

  logic [WIDTH-1:0]       r_sync [SYNC_STAGES];
  logic [WIDTH-1:0]       r_prev;
  logic [c_ARM_CNT_W-1:0] r_arm_cnt;
  logic                   r_armed;
  logic [WIDTH-1:0]       w_edge_raw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign data_in = r_sync[SYNC_STAGES-1];

  // The chain resets to zero, so a level held through reset looks like an
  // edge once it propagates. Arming SYNC_STAGES+1 cycles after release
  // ensures data_in and prev have both settled before edges are accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_arm_cnt <= '0;
      r_armed   <= 1'b0;
    end else if (!r_armed) begin
      if (r_arm_cnt == c_ARM_CNT_W'(SYNC_STAGES)) r_armed <= 1'b1;
      else                                         r_arm_cnt <= r_arm_cnt + 1'b1;
    end
  end

  if (EDGE_TYPE == EDGE_RISE) begin : g_rise
    assign w_edge_raw = data_in & ~r_prev;
  end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
    assign w_edge_raw = ~data_in & r_prev;
  end else begin : g_any
    assign w_edge_raw = data_in ^ r_prev;
  end

  assign edge_det = r_armed ? w_edge_raw : '0;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("pio_sync_edge: SYNC_STAGES must be 2..4");
  end
  if (EDGE_TYPE < 0 || EDGE_TYPE > 2) begin : g_bad_edge_type
    $error("pio_sync_edge: EDGE_TYPE must be 0..2");
  end

endmodule : pio_sync_edge
`default_nettype wire

// File: rtl/nios_pio_in_edge.sv
`default_nettype none
// ============================================================================
// Module      : nios_pio_in_edge
// Description : Avalon-MM slave input PIO. Exposes a synchronised input bus,
//               sticky per-bit edge-capture flags (write-1-to-clear), an
//               interrupt mask, and a level interrupt.
// Ports       : clk, reset_n        - clock, asynchronous active-low reset
//               address[1:0]        - 0 data, 1 reserved, 2 irqmask, 3 edgecap
//               chipselect, write_n - slave select, active-low write strobe
//               writedata[31:0]     - write data (bits above WIDTH ignored)
//               in_port[WIDTH]      - asynchronous external inputs
//               readdata[31:0]      - registered read data, 1-cycle latency
//               irq                 - level interrupt
// Revision    : 1.0 - initial release
// ============================================================================
module nios_pio_in_edge
  import nios_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] w_data_in;
  logic [WIDTH-1:0] w_edge_det;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;
  logic [31:0]      w_rd_mux;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_capture;
  logic [31:0]      r_readdata;

  pio_sync_edge #(
    .WIDTH       (WIDTH),
    .EDGE_TYPE   (EDGE_TYPE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .data_in  (w_data_in),
    .edge_det (w_edge_det)
  );

  assign w_wr  = chipselect & ~write_n;
  assign w_clr = (w_wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_mask     <= '0;
      r_edge_capture <= '0;
    end else begin
      if (w_wr && address == ADDR_IRQMASK) r_irq_mask <= writedata[WIDTH-1:0];
      // A new edge in the same cycle as its clear must not be lost
      r_edge_capture <= (r_edge_capture & ~w_clr) | w_edge_det;
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA:    w_rd_mux = 32'(w_data_in);
      ADDR_IRQMASK: w_rd_mux = 32'(r_irq_mask);
      ADDR_EDGECAP: w_rd_mux = 32'(r_edge_capture);
      default:      w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        r_readdata <= '0;
    else if (chipselect) r_readdata <= w_rd_mux;
  end

  assign readdata = r_readdata;
  assign irq      = |(r_edge_capture & r_irq_mask);

  if (WIDTH < 32) begin : g_wdata_unused
    logic w_unused_wdata;
    assign w_unused_wdata = &{1'b0, writedata[31:WIDTH]};
  end

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("nios_pio_in_edge: WIDTH must be 1..32");
  end

endmodule : nios_pio_in_edge
`default_nettype wire
